// File: rtl/i2c_pad_conditioner_if.sv
// i2c_pad_conditioner_if: pad, core and recovery signals of the I2C pad conditioner
// Pad side   : scl/sda_pad_in raw pin levels, scl/sda_pad_oe pull-low enables.
// Core side  : core_scl/sda_oe pull-low requests, core_scl/sda_in filtered levels.
// Status     : bus_busy, start_det, stop_det, stuck_low.
// Recovery   : recover_req in; recover_busy, recover_done, recover_ok out.
// The slave modport is the conditioner's view; master is the surrounding system.
interface i2c_pad_conditioner_if;
  logic scl_pad_in, sda_pad_in, core_scl_oe, core_sda_oe, recover_req;
  logic scl_pad_oe, sda_pad_oe, core_scl_in, core_sda_in;
  logic bus_busy, start_det, stop_det, stuck_low;
  logic recover_busy, recover_done, recover_ok;
  modport slave (
    input  scl_pad_in, sda_pad_in, core_scl_oe, core_sda_oe, recover_req,
    output scl_pad_oe, sda_pad_oe, core_scl_in, core_sda_in,
    output bus_busy, start_det, stop_det, stuck_low,
    output recover_busy, recover_done, recover_ok
  );
  modport master (
    output scl_pad_in, sda_pad_in, core_scl_oe, core_sda_oe, recover_req,
    input  scl_pad_oe, sda_pad_oe, core_scl_in, core_sda_in,
    input  bus_busy, start_det, stop_det, stuck_low,
    input  recover_busy, recover_done, recover_ok
  );
endinterface

// File: rtl/i2c_pad_conditioner.sv
// i2c_pad_conditioner: I2C pad synchronizer/glitch filter, START/STOP and stuck detection, bus-clear recovery
// Ports:
//   clk_riscv : system clock
//   rst_in    : asynchronous active-low reset
//   bus       : i2c_pad_conditioner_if.slave (pads, core view, status, recovery handshake)
// Line index 0 is SCL and 1 is SDA in the packed filter vectors.
module i2c_pad_conditioner #(
  parameter int FILT_LEN     = 3,
  parameter int RECOV_HALF   = 250,
  parameter int STUCK_CYCLES = 2400000
) (
  input logic clk_riscv,
  input logic rst_in,
  i2c_pad_conditioner_if.slave bus
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int HW = $clog2(RECOV_HALF + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, STOP_A, STOP_B, STOP_C, DONE} state_t;
  state_t state;
  logic [1:0] s1, s2, filt, filt_q;
  logic [1:0][FW-1:0] fcnt;
  logic [HW-1:0] tmr;
  logic [SW-1:0] wait_cnt, stuck_cnt;
  logic [3:0] pulses;
  logic recover_busy, recover_done, recover_ok, fsm_scl_oe, fsm_sda_oe;
  logic bus_busy, stuck_low, scl_pad_oe, sda_pad_oe;
  logic scl_f, sda_f, scl_hi, start_det, stop_det, stuck_run, done_ok, half_end, wait_end;
  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_hi    = filt[0] & filt_q[0];
  assign start_det = !recover_busy & scl_hi & filt_q[1] & !filt[1];
  assign stop_det  = !recover_busy & scl_hi & !filt_q[1] & filt[1];
  // SDA low only counts as stuck outside a transaction; SCL low always does
  assign stuck_run = !scl_f | (!sda_f & !bus_busy);
  assign done_ok   = recover_done & recover_ok;
  assign half_end  = tmr == HW'(RECOV_HALF - 1);
  assign wait_end  = wait_cnt == SW'(STUCK_CYCLES - 1);
  always_ff @(posedge clk_riscv or negedge rst_in)
    if (!rst_in) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      fcnt <= '0;
    end else begin
      s1 <= {bus.sda_pad_in, bus.scl_pad_in};
      s2 <= s1;
      for (int i = 0; i < 2; i++)
        if (s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 1'b1;
    end
  always_ff @(posedge clk_riscv or negedge rst_in)
    if (!rst_in) begin
      filt_q     <= '1;
      bus_busy   <= 1'b0;
      stuck_cnt  <= '0;
      stuck_low  <= 1'b0;
      scl_pad_oe <= 1'b0;
      sda_pad_oe <= 1'b0;
    end else begin
      filt_q     <= filt;
      bus_busy   <= done_ok ? 1'b0 : start_det ? 1'b1 : stop_det ? 1'b0 : bus_busy;
      stuck_low  <= (stuck_low | (!recover_busy & stuck_run & stuck_cnt == SW'(STUCK_CYCLES - 1))) & !done_ok;
      scl_pad_oe <= recover_busy ? fsm_scl_oe : bus.core_scl_oe;
      sda_pad_oe <= recover_busy ? fsm_sda_oe : bus.core_sda_oe;
      if (!recover_busy)
        stuck_cnt <= !stuck_run ? '0 : stuck_cnt == SW'(STUCK_CYCLES) ? stuck_cnt : stuck_cnt + 1'b1;
    end
  // Phases that release a line restart their half-phase timer while the filtered
  // line is still low, so clock stretching and filter latency only lengthen them;
  // wait_cnt bounds that wait. The final released phase waits for both lines so a
  // healthy bus is never judged on stale filtered values.
  always_ff @(posedge clk_riscv or negedge rst_in)
    if (!rst_in) begin
      state        <= IDLE;
      tmr          <= '0;
      wait_cnt     <= '0;
      pulses       <= '0;
      recover_busy <= 1'b0;
      recover_done <= 1'b0;
      recover_ok   <= 1'b0;
      fsm_scl_oe   <= 1'b0;
      fsm_sda_oe   <= 1'b0;
    end else begin
      recover_done <= 1'b0;
      case (state)
        IDLE: if (bus.recover_req) begin
          if (!bus_busy | stuck_low) begin
            state        <= LOW;
            recover_busy <= 1'b1;
            recover_ok   <= 1'b0;
            fsm_scl_oe   <= 1'b1;
            fsm_sda_oe   <= 1'b0;
            tmr          <= '0;
            pulses       <= '0;
          end else begin
            state        <= DONE;
            recover_done <= 1'b1;
            recover_ok   <= 1'b0;
          end
        end
        LOW: if (half_end) begin
          state      <= HIGH;
          fsm_scl_oe <= 1'b0;
          pulses     <= pulses + 4'd1;
          tmr        <= '0;
          wait_cnt   <= '0;
        end else tmr <= tmr + 1'b1;
        HIGH: if (!scl_f) begin
          tmr      <= '0;
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_end) begin
            state        <= DONE;
            recover_busy <= 1'b0;
            recover_done <= 1'b1;
            recover_ok   <= 1'b0;
          end
        end else if (!half_end) tmr <= tmr + 1'b1;
        else if (sda_f) begin
          state      <= STOP_A;
          fsm_scl_oe <= 1'b1;
          fsm_sda_oe <= 1'b1;
          tmr        <= '0;
        end else if (pulses == 4'd9) begin
          state        <= DONE;
          recover_busy <= 1'b0;
          recover_done <= 1'b1;
          recover_ok   <= 1'b0;
        end else begin
          state      <= LOW;
          fsm_scl_oe <= 1'b1;
          tmr        <= '0;
        end
        STOP_A: if (half_end) begin
          state      <= STOP_B;
          fsm_scl_oe <= 1'b0;
          tmr        <= '0;
        end else tmr <= tmr + 1'b1;
        STOP_B: if (half_end) begin
          state      <= STOP_C;
          fsm_sda_oe <= 1'b0;
          tmr        <= '0;
          wait_cnt   <= '0;
        end else tmr <= tmr + 1'b1;
        STOP_C: if (!(scl_f & sda_f)) begin
          tmr      <= '0;
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_end) begin
            state        <= DONE;
            recover_busy <= 1'b0;
            recover_done <= 1'b1;
            recover_ok   <= 1'b0;
          end
        end else if (half_end) begin
          state        <= DONE;
          recover_busy <= 1'b0;
          recover_done <= 1'b1;
          recover_ok   <= scl_f & sda_f;
        end else tmr <= tmr + 1'b1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign bus.scl_pad_oe   = scl_pad_oe;
  assign bus.sda_pad_oe   = sda_pad_oe;
  assign bus.core_scl_in  = recover_busy | scl_f;
  assign bus.core_sda_in  = recover_busy | sda_f;
  assign bus.bus_busy     = bus_busy;
  assign bus.start_det    = start_det;
  assign bus.stop_det     = stop_det;
  assign bus.stuck_low    = stuck_low;
  assign bus.recover_busy = recover_busy;
  assign bus.recover_done = recover_done;
  assign bus.recover_ok   = recover_ok;
endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// tb_i2c_pad_conditioner: directed self-checking bench for i2c_pad_conditioner
// Pads are modelled open-drain: a pin is high only when neither the DUT nor the
// bench-side device (ext_scl/ext_sda) pulls it low.
module tb_i2c_pad_conditioner;
  logic clk_riscv = 1'b0;
  logic rst_in = 1'b0;
  logic ext_scl = 1'b1;
  logic ext_sda = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int start_tot = 0, stop_tot = 0, done_tot = 0, scl_rise_tot = 0, sda_rise_tot = 0;
  int bad_run_tot = 0, bad_core_tot = 0, scl_run = 0, sda_run = 0, last_sda_run = 0;
  logic scl_oe_q = 1'b0, sda_oe_q = 1'b0;
  int b_start, b_stop, b_done, b_scl, b_sda, b_run, b_core;
  logic low_seen;
  i2c_pad_conditioner_if bus ();
  i2c_pad_conditioner #(.FILT_LEN(3), .RECOV_HALF(4), .STUCK_CYCLES(64)) dut (
    .clk_riscv(clk_riscv),
    .rst_in(rst_in),
    .bus(bus.slave)
  );
  assign bus.scl_pad_in = ext_scl & ~bus.scl_pad_oe;
  assign bus.sda_pad_in = ext_sda & ~bus.sda_pad_oe;
  always #5 clk_riscv = ~clk_riscv;
  always @(negedge clk_riscv) begin
    start_tot    <= start_tot + int'(bus.start_det);
    stop_tot     <= stop_tot + int'(bus.stop_det);
    done_tot     <= done_tot + int'(bus.recover_done);
    scl_rise_tot <= scl_rise_tot + int'(bus.scl_pad_oe & ~scl_oe_q);
    sda_rise_tot <= sda_rise_tot + int'(bus.sda_pad_oe & ~sda_oe_q);
    scl_oe_q     <= bus.scl_pad_oe;
    sda_oe_q     <= bus.sda_pad_oe;
    bad_core_tot <= bad_core_tot + int'(bus.recover_busy & ~(bus.core_scl_in & bus.core_sda_in));
    scl_run      <= bus.scl_pad_oe ? scl_run + 1 : 0;
    bad_run_tot  <= bad_run_tot + int'(!bus.scl_pad_oe && scl_run != 0 && scl_run != 4);
    sda_run      <= bus.sda_pad_oe ? sda_run + 1 : 0;
    if (!bus.sda_pad_oe && sda_run != 0) last_sda_run <= sda_run;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_riscv);
    #1;
  endtask
  task automatic wait_done(input int base, input int budget, input string tag);
    int n = 0;
    while (done_tot == base && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(done_tot != base), 1);
  endtask
  task automatic wait_rises(input int base, input int cnt, input int budget, input string tag);
    int n = 0;
    while (scl_rise_tot - base < cnt && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(scl_rise_tot - base >= cnt), 1);
  endtask
  task automatic snap();
    b_start = start_tot;
    b_stop  = stop_tot;
    b_done  = done_tot;
    b_scl   = scl_rise_tot;
    b_sda   = sda_rise_tot;
    b_run   = bad_run_tot;
    b_core  = bad_core_tot;
  endtask
  task automatic request();
    bus.recover_req = 1'b1;
    tick(1);
    bus.recover_req = 1'b0;
  endtask
  initial begin
    bus.core_scl_oe = 1'b0;
    bus.core_sda_oe = 1'b0;
    bus.recover_req = 1'b0;
    tick(3);
    check("rst_scl_pad_oe", bus.scl_pad_oe, 0);
    check("rst_sda_pad_oe", bus.sda_pad_oe, 0);
    check("rst_core_scl_in", bus.core_scl_in, 1);
    check("rst_core_sda_in", bus.core_sda_in, 1);
    check("rst_bus_busy", bus.bus_busy, 0);
    check("rst_stuck_low", bus.stuck_low, 0);
    check("rst_recover_busy", bus.recover_busy, 0);
    check("rst_recover_ok", bus.recover_ok, 0);
    rst_in = 1'b1;
    tick(5);
    ext_sda = 1'b0;
    tick(2);
    ext_sda = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!bus.core_sda_in) low_seen = 1'b1;
    end
    check("glitch2_rejected", low_seen, 0);
    ext_sda = 1'b0;
    tick(3);
    ext_sda = 1'b1;
    tick(1);
    check("glitch3_before", bus.core_sda_in, 1);
    tick(1);
    check("glitch3_fall_at_5", bus.core_sda_in, 0);
    tick(15);
    snap();
    ext_sda = 1'b0;
    tick(10);
    check("start_pulses", start_tot - b_start, 1);
    check("start_bus_busy", bus.bus_busy, 1);
    check("start_no_stop", stop_tot - b_stop, 0);
    ext_sda = 1'b1;
    tick(10);
    check("stop_pulses", stop_tot - b_stop, 1);
    check("stop_bus_busy", bus.bus_busy, 0);
    snap();
    ext_scl = 1'b0;
    ext_sda = 1'b0;
    tick(10);
    ext_scl = 1'b1;
    ext_sda = 1'b1;
    tick(10);
    check("same_cycle_start", start_tot - b_start, 0);
    check("same_cycle_stop", stop_tot - b_stop, 0);
    check("same_cycle_busy", bus.bus_busy, 0);
    ext_scl = 1'b0;
    ext_sda = 1'b0;
    tick(10);
    ext_scl = 1'b1;
    tick(58);
    check("stuck_at_63", bus.stuck_low, 0);
    tick(1);
    check("stuck_at_64", bus.stuck_low, 1);
    ext_sda = 1'b1;
    tick(20);
    check("stuck_sticky", bus.stuck_low, 1);
    ext_sda = 1'b0;
    tick(10);
    check("succ_pre_busy", bus.bus_busy, 1);
    snap();
    request();
    check("succ_recover_busy", bus.recover_busy, 1);
    check("succ_core_sda_forced", bus.core_sda_in, 1);
    wait_rises(b_scl, 3, 100, "succ_third_pulse");
    ext_sda = 1'b1;
    wait_done(b_done, 300, "succ_done");
    check("succ_ok", bus.recover_ok, 1);
    check("succ_scl_pulses", scl_rise_tot - b_scl, 4);
    check("succ_sda_pulses", sda_rise_tot - b_sda, 1);
    check("succ_scl_pulse_len", bad_run_tot - b_run, 0);
    check("succ_stop_sda_len", last_sda_run, 8);
    check("succ_core_forced", bad_core_tot - b_core, 0);
    tick(2);
    check("succ_stuck_cleared", bus.stuck_low, 0);
    check("succ_bus_idle", bus.bus_busy, 0);
    check("succ_single_done", done_tot - b_done, 1);
    tick(10);
    ext_sda = 1'b0;
    tick(10);
    check("rej_pre_busy", bus.bus_busy, 1);
    check("rej_pre_stuck", bus.stuck_low, 0);
    snap();
    request();
    check("rej_done", bus.recover_done, 1);
    check("rej_ok", bus.recover_ok, 0);
    check("rej_not_busy", bus.recover_busy, 0);
    tick(1);
    check("rej_done_one_cycle", bus.recover_done, 0);
    tick(5);
    check("rej_scl_idle", scl_rise_tot - b_scl, 0);
    check("rej_sda_idle", sda_rise_tot - b_sda, 0);
    ext_sda = 1'b1;
    tick(10);
    check("rej_stop_busy", bus.bus_busy, 0);
    bus.core_scl_oe = 1'b1;
    bus.core_sda_oe = 1'b1;
    check("pass_scl_before", bus.scl_pad_oe, 0);
    tick(1);
    check("pass_scl_oe", bus.scl_pad_oe, 1);
    check("pass_sda_oe", bus.sda_pad_oe, 1);
    bus.core_scl_oe = 1'b0;
    bus.core_sda_oe = 1'b0;
    tick(1);
    check("pass_scl_release", bus.scl_pad_oe, 0);
    tick(15);
    ext_scl = 1'b0;
    ext_sda = 1'b0;
    tick(10);
    ext_scl = 1'b1;
    tick(70);
    check("fail_pre_stuck", bus.stuck_low, 1);
    check("fail_pre_busy", bus.bus_busy, 0);
    snap();
    request();
    wait_done(b_done, 600, "fail_done");
    check("fail_ok", bus.recover_ok, 0);
    check("fail_scl_pulses", scl_rise_tot - b_scl, 9);
    check("fail_no_stop", sda_rise_tot - b_sda, 0);
    check("fail_scl_pulse_len", bad_run_tot - b_run, 0);
    tick(2);
    check("fail_stuck_kept", bus.stuck_low, 1);
    ext_sda = 1'b1;
    tick(10);
    snap();
    request();
    tick(1);
    check("rst_mid_low_scl", bus.scl_pad_oe, 1);
    rst_in = 1'b0;
    #1;
    check("rst_async_scl", bus.scl_pad_oe, 0);
    check("rst_async_busy", bus.recover_busy, 0);
    tick(3);
    rst_in = 1'b1;
    tick(10);
    check("rst_no_done", done_tot - b_done, 0);
    check("rst_stuck_clear", bus.stuck_low, 0);
    check("rst_scl_idle", bus.scl_pad_oe, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
